// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding register per functional unit,
// round-robin grant onto a registered CDB broadcast.

module cdb_hold #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_in,
    input  logic         accept,
    input  logic         grant,
    input  logic [W-1:0] data,
    output logic         valid,
    output logic [W-1:0] q
);
    // accept outranks grant so a granted entry can be refilled in the same cycle
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in)
            valid <= 1'b0;
        else if (accept)
            valid <= 1'b1;
        else if (grant)
            valid <= 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (accept)
            q <= data;
    end
endmodule

module cdb_arbiter #(
    parameter int NUM_FU   = 4,
    parameter int ROB_IX_W = 3,
    parameter int DATA_W   = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         flush_in,
    input  logic [NUM_FU-1:0]            fu_valid_in,
    input  logic [NUM_FU*ROB_IX_W-1:0]   fu_rob_ix_in,
    input  logic [NUM_FU*DATA_W-1:0]     fu_value_in,
    input  logic [NUM_FU*DATA_W-1:0]     fu_dest_in,
    output logic [NUM_FU-1:0]            fu_ready_out,
    output logic                         cdb_valid_out,
    output logic [ROB_IX_W-1:0]          cdb_rob_ix_out,
    output logic [DATA_W-1:0]            cdb_value_out,
    output logic [DATA_W-1:0]            cdb_dest_out,
    output logic [$clog2(NUM_FU)-1:0]    cdb_src_out
);
    localparam int PTR_W = $clog2(NUM_FU);

    typedef struct packed {
        logic [ROB_IX_W-1:0] rob_ix;
        logic [DATA_W-1:0]   value;
        logic [DATA_W-1:0]   dest;
    } entry_t;

    entry_t [NUM_FU-1:0] fu_entry;
    entry_t [NUM_FU-1:0] hold_entry;
    logic   [NUM_FU-1:0] hold_valid;
    logic   [NUM_FU-1:0] grant;
    logic   [NUM_FU-1:0] accept;
    logic   [PTR_W-1:0]  rr_ptr;
    logic   [PTR_W-1:0]  gnt_ix;
    logic                gnt_any;
    entry_t              cdb_q;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        assign fu_entry[g].rob_ix = fu_rob_ix_in[g*ROB_IX_W +: ROB_IX_W];
        assign fu_entry[g].value  = fu_value_in[g*DATA_W +: DATA_W];
        assign fu_entry[g].dest   = fu_dest_in[g*DATA_W +: DATA_W];
        assign fu_ready_out[g]    = !rst_in && !flush_in && (!hold_valid[g] || grant[g]);
        assign accept[g]          = fu_valid_in[g] && fu_ready_out[g];

        cdb_hold #(.W($bits(entry_t))) u_hold (
            .clk_in   (clk_in),
            .rst_in   (rst_in),
            .flush_in (flush_in),
            .accept   (accept[g]),
            .grant    (grant[g]),
            .data     (fu_entry[g]),
            .valid    (hold_valid[g]),
            .q        (hold_entry[g])
        );
    end

    // first held entry at or above rr_ptr, wrapping modulo NUM_FU
    always_comb begin
        int idx;
        grant   = '0;
        gnt_ix  = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_FU)
                idx = idx - NUM_FU;
            if (!gnt_any && hold_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_ix  = idx[PTR_W-1:0];
            end
        end
        if (gnt_any)
            grant[gnt_ix] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_ptr        <= '0;
            cdb_valid_out <= 1'b0;
            cdb_q         <= '0;
            cdb_src_out   <= '0;
        end else if (flush_in) begin
            cdb_valid_out <= 1'b0;
        end else if (gnt_any) begin
            rr_ptr        <= (gnt_ix == PTR_W'(NUM_FU-1)) ? '0 : gnt_ix + 1'b1;
            cdb_valid_out <= 1'b1;
            cdb_q         <= hold_entry[gnt_ix];
            cdb_src_out   <= gnt_ix;
        end else begin
            cdb_valid_out <= 1'b0;
        end
    end

    assign cdb_rob_ix_out = cdb_q.rob_ix;
    assign cdb_value_out  = cdb_q.value;
    assign cdb_dest_out   = cdb_q.dest;
endmodule
